// File: rtl/mem_arb.sv
// Two-requester arbiter for a single-ported memory: load/store normally wins,
// and a fetch that has lost STARVE_MAX cycles in a row takes priority.
module mem_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic [31:0] m_addr,
  output logic [2:0]  m_sel,
  output logic        m_wen,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_e;

  owner_e     owner_q;
  logic       rd_q;
  logic       err_q;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       if_bad;
  logic       ls_bad;
  logic       fetch_first;

  assign if_bad = (if_addr[1:0] != 2'b00);

  always_comb begin
    ls_bad = 1'b0;
    case (ls_funct3)
      3'b000:  ls_bad = 1'b0;
      3'b100:  ls_bad = ls_we;
      3'b001:  ls_bad = ls_addr[0];
      3'b101:  ls_bad = ls_we | ls_addr[0];
      3'b010:  ls_bad = (ls_addr[1:0] != 2'b00);
      default: ls_bad = 1'b1;
    endcase
  end

  // Grant stage: combinational from current requests and starvation state
  assign fetch_first = (starve_q == STARVE_LIM);
  assign if_gnt      = ~rst & if_req & (~ls_req | fetch_first);
  assign ls_gnt      = ~rst & ls_req & ~(if_req & fetch_first);

  always_comb begin
    m_addr  = '0;
    m_sel   = 3'b010;
    m_wen   = 1'b0;
    m_wdata = '0;
    if (if_gnt) begin
      m_addr = if_addr;
    end else if (ls_gnt) begin
      m_addr  = ls_addr;
      m_sel   = ls_funct3;
      m_wen   = ls_we & ~ls_bad;
      m_wdata = ls_wdata;
    end
  end

  always_comb begin
    if (!if_req || if_gnt)
      starve_d = 4'd0;
    else if (starve_q < STARVE_LIM)
      starve_d = starve_q + 4'd1;
    else
      starve_d = starve_q;
  end

  // Response stage: the owner of the access issued last cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
      if (if_gnt) begin
        owner_q <= OWN_IF;
        rd_q    <= 1'b1;
        err_q   <= if_bad;
      end else if (ls_gnt) begin
        owner_q <= OWN_LS;
        rd_q    <= ~ls_we;
        err_q   <= ls_bad;
      end else begin
        owner_q <= OWN_NONE;
        rd_q    <= 1'b0;
        err_q   <= 1'b0;
      end
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign if_err    = if_rvalid & err_q;
  assign if_rdata  = (if_rvalid & rd_q & ~err_q) ? m_rdata : '0;
  assign ls_rvalid = (owner_q == OWN_LS);
  assign ls_err    = ls_rvalid & err_q;
  assign ls_rdata  = (ls_rvalid & rd_q & ~err_q) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: a byte-addressed memory device on port A plus a
// transaction-level reference model of grants, responses and memory contents.
module tb_mem_arb;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_sel;
  logic        m_wen;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .m_addr(m_addr), .m_sel(m_sel), .m_wen(m_wen), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Memory device: 64 words, registered read with sign/zero extension
  logic [31:0] dev_w [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_a  = '0;
  logic [31:0] bd_d  = '0;
  logic [31:0] wmask;
  logic [4:0]  wsh;

  always_comb begin
    wsh = {m_addr[1:0], 3'b000};
    case (m_sel[1:0])
      2'b00:   wmask = 32'hFF << wsh;
      2'b01:   wmask = 32'hFFFF << wsh;
      default: wmask = 32'hFFFF_FFFF;
    endcase
  end

  function automatic logic [31:0] dev_rd(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'b0, s[15:0]};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bd_we)
      dev_w[bd_a] <= bd_d;
    else if (m_wen)
      dev_w[m_addr[7:2]] <= (dev_w[m_addr[7:2]] & ~wmask) | ((m_wdata << wsh) & wmask);
    m_rdata <= dev_rd(dev_w[m_addr[7:2]], m_addr[1:0], m_sel);
  end

  // Reference model
  logic [7:0]  ref_b [256];
  int          starve_m;
  int          pend_kind;   // 0 none, 1 fetch, 2 load/store
  logic        pend_err;
  logic [31:0] pend_data;
  logic        e_if_gnt, e_ls_gnt, e_wen;
  logic [31:0] e_addr, e_wdata;
  logic [2:0]  e_sel;

  function automatic logic ls_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (we && (f3 == 3'b100 || f3 == 3'b101)) bad = 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) bad = 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] i, b0, b1, b2, b3;
    i  = a[7:0];
    b0 = ref_b[i];
    b1 = ref_b[i + 8'd1];
    b2 = ref_b[i + 8'd2];
    b3 = ref_b[i + 8'd3];
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'b0, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b101:  return {16'b0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_b[a[7:0] + 8'(k)] = d[8*k +: 8];
  endtask

  task automatic model_reset();
    starve_m = 0; pend_kind = 0; pend_err = 1'b0; pend_data = '0;
  endtask

  task automatic model_eval();
    e_if_gnt = !rst && if_req && (!ls_req || starve_m >= SM);
    e_ls_gnt = !rst && ls_req && !e_if_gnt;
    e_addr = '0; e_sel = 3'b010; e_wen = 1'b0; e_wdata = '0;
    if (e_if_gnt) e_addr = if_addr;
    if (e_ls_gnt) begin
      e_addr = ls_addr; e_sel = ls_funct3; e_wdata = ls_wdata;
      e_wen  = ls_we && !ls_illegal(ls_we, ls_funct3, ls_addr);
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      model_reset();
    end else begin
      if (!if_req || e_if_gnt) starve_m = 0;
      else if (starve_m < SM) starve_m++;
      pend_kind = 0; pend_err = 1'b0; pend_data = '0;
      if (e_if_gnt) begin
        pend_kind = 1;
        pend_err  = (if_addr[1:0] != 2'b00);
        pend_data = pend_err ? 32'h0 : ref_load(if_addr, 3'b010);
      end else if (e_ls_gnt) begin
        pend_kind = 2;
        pend_err  = ls_illegal(ls_we, ls_funct3, ls_addr);
        pend_data = (pend_err || ls_we) ? 32'h0 : ref_load(ls_addr, ls_funct3);
        if (!pend_err && ls_we) ref_store(ls_addr, ls_funct3, ls_wdata);
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    model_eval();
  endtask

  task automatic fin();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic preload();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = (i == 2) ? 32'h00A00093 : $urandom;
      bd_we = 1'b1; bd_a = 6'(i); bd_d = w;
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = w[8*k +: 8];
      @(posedge clk); #1;
    end
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    if_req = 1'b1; if_addr = 32'h4; ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b010;
    ls_addr = 32'h8; ls_wdata = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, m_wen} !== 3'b000) begin
      n_bad++; $display("FAIL reset_grant: got gnt/wen=%b want 000", {if_gnt, ls_gnt, m_wen});
    end
    n_cmp++;
    if ({if_rvalid, ls_rvalid, if_err, ls_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_resp: got rvalid/err=%b want 0000", {if_rvalid, ls_rvalid, if_err, ls_err});
    end
    n_cmp++;
    if ({if_rdata, ls_rdata} !== 64'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, ls_rdata);
    end
    fin();
    if_req = 1'b0; ls_req = 1'b0; rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      half();
      n_cmp++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, m_addr, m_sel, m_wen, m_wdata} !== {4'b0, 32'h0, 3'b010, 1'b0, 32'h0}) begin
        n_bad++; $display("FAIL idle_after_reset: got gnt/rv=%b addr=%h sel=%b wen=%b wdata=%h want 0000/0/010/0/0",
                          {if_gnt, ls_gnt, if_rvalid, ls_rvalid}, m_addr, m_sel, m_wen, m_wdata);
      end
      fin();
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h8;
    half();
    n_cmp++;
    if ({if_gnt, ls_gnt, m_addr, m_sel, m_wen} !== {2'b10, 32'h8, 3'b010, 1'b0}) begin
      n_bad++; $display("FAIL fetch_grant: got gnt=%b addr=%h sel=%b wen=%b want 10/8/010/0",
                        {if_gnt, ls_gnt}, m_addr, m_sel, m_wen);
    end
    fin();
    if_addr = 32'h6;
    half();
    n_cmp++;
    if ({if_rvalid, if_err, if_rdata, if_gnt} !== {2'b10, 32'h00A00093, 1'b1}) begin
      n_bad++; $display("FAIL fetch_resp: got rv=%b err=%b data=%h gnt=%b want 1/0/00a00093/1",
                        if_rvalid, if_err, if_rdata, if_gnt);
    end
    fin();
    if_req = 1'b0;
    half();
    n_cmp++;
    if ({if_rvalid, if_err, if_rdata} !== {2'b11, 32'h0}) begin
      n_bad++; $display("FAIL fetch_misaligned: got rv=%b err=%b data=%h want 1/1/0", if_rvalid, if_err, if_rdata);
    end
    fin();
  endtask

  task automatic test_contention();
    logic prev_if;
    prev_if = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h20;
    for (int c = 0; c < 10; c++) begin
      half();
      n_cmp++;
      if ({if_gnt, ls_gnt} !== {c % 5 == 4, c % 5 != 4}) begin
        n_bad++; $display("FAIL contention_c%0d: got if/ls gnt=%b%b want %b%b",
                          c, if_gnt, ls_gnt, c % 5 == 4, c % 5 != 4);
      end
      if (c > 0) begin
        n_cmp++;
        if ({if_rvalid, ls_rvalid} !== {prev_if, !prev_if}) begin
          n_bad++; $display("FAIL contention_rv_c%0d: got if/ls rvalid=%b%b want %b%b",
                            c, if_rvalid, ls_rvalid, prev_if, !prev_if);
        end
      end
      prev_if = (c % 5 == 4);
      fin();
    end
    if_req = 1'b0; ls_req = 1'b0;
    fin();
  endtask

  task automatic test_back_to_back();
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h10; ls_wdata = 32'hDEADBEEF;
    half();
    n_cmp++;
    if ({ls_gnt, m_wen, m_addr, m_sel, m_wdata} !== {2'b11, 32'h10, 3'b010, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL store_grant: got gnt=%b wen=%b addr=%h sel=%b wdata=%h want 1/1/10/010/deadbeef",
                        ls_gnt, m_wen, m_addr, m_sel, m_wdata);
    end
    fin();
    ls_we = 1'b0; ls_funct3 = 3'b000; ls_addr = 32'h13;
    half();
    n_cmp++;
    if ({ls_gnt, ls_rvalid, ls_err, ls_rdata} !== {3'b110, 32'h0}) begin
      n_bad++; $display("FAIL store_ack: got gnt=%b rv=%b err=%b data=%h want 1/1/0/0",
                        ls_gnt, ls_rvalid, ls_err, ls_rdata);
    end
    fin();
    ls_req = 1'b0;
    half();
    n_cmp++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b10, 32'hFFFFFFDE}) begin
      n_bad++; $display("FAIL load_byte: got rv=%b err=%b data=%h want 1/0/ffffffde", ls_rvalid, ls_err, ls_rdata);
    end
    fin();
  endtask

  task automatic test_misaligned();
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h12;
    half();
    n_cmp++;
    if ({ls_gnt, m_wen} !== 2'b10) begin
      n_bad++; $display("FAIL lw_misaligned_grant: got gnt=%b wen=%b want 1/0", ls_gnt, m_wen);
    end
    fin();
    ls_we = 1'b1; ls_funct3 = 3'b001; ls_addr = 32'h11; ls_wdata = 32'h0000_1234;
    half();
    n_cmp++;
    if ({ls_gnt, m_wen, ls_rvalid, ls_err, ls_rdata} !== {4'b1011, 32'h0}) begin
      n_bad++; $display("FAIL sh_misaligned: got gnt=%b wen=%b rv=%b err=%b data=%h want 1/0/1/1/0",
                        ls_gnt, m_wen, ls_rvalid, ls_err, ls_rdata);
    end
    fin();
    ls_req = 1'b0;
    half();
    n_cmp++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b11, 32'h0}) begin
      n_bad++; $display("FAIL sh_misaligned_resp: got rv=%b err=%b data=%h want 1/1/0", ls_rvalid, ls_err, ls_rdata);
    end
    fin();
    n_cmp++;
    if (dev_w[4] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL misaligned_mem: got word4=%h want deadbeef", dev_w[4]);
    end
  endtask

  task automatic test_reset_mid();
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h10;
    half();
    fin();
    ls_req = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b00, 32'h0}) begin
      n_bad++; $display("FAIL reset_mid_resp: got rv=%b err=%b data=%h want 0/0/0", ls_rvalid, ls_err, ls_rdata);
    end
    fin();
    fin();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      half();
      n_cmp++;
      if ({if_rvalid, ls_rvalid} !== 2'b00) begin
        n_bad++; $display("FAIL reset_mid_stale_c%0d: got if/ls rvalid=%b%b want 00", c, if_rvalid, ls_rvalid);
      end
      fin();
    end
    ls_req = 1'b1;
    half();
    fin();
    ls_req = 1'b0;
    half();
    n_cmp++;
    if ({ls_rvalid, ls_err, ls_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL reset_mid_new: got rv=%b err=%b data=%h want 1/0/deadbeef", ls_rvalid, ls_err, ls_rdata);
    end
    fin();
  endtask

  task automatic test_random();
    logic [2:0]  legal [5];
    logic [69:0] got_a, exp_a;
    logic [67:0] got_b, exp_b;
    int          sz;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int c = 0; c < 400; c++) begin
      half();
      got_a = {if_gnt, ls_gnt, m_addr, m_sel, m_wen, m_wdata};
      exp_a = {e_if_gnt, e_ls_gnt, e_addr, e_sel, e_wen, e_wdata};
      got_b = {if_rvalid, if_err, if_rdata, ls_rvalid, ls_err, ls_rdata};
      exp_b = {pend_kind == 1, pend_kind == 1 && pend_err, (pend_kind == 1) ? pend_data : 32'h0,
               pend_kind == 2, pend_kind == 2 && pend_err, (pend_kind == 2) ? pend_data : 32'h0};
      n_cmp++;
      if (got_a !== exp_a) begin
        n_bad++; $display("FAIL random_port_c%0d: got %h want %h", c, got_a, exp_a);
      end
      n_cmp++;
      if (got_b !== exp_b) begin
        n_bad++; $display("FAIL random_resp_c%0d: got %h want %h", c, got_b, exp_b);
      end
      fin();
      if (!if_req || e_if_gnt) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 5) != 0) if_addr[1:0] = 2'b00;
      end
      if (!ls_req || e_ls_gnt) begin
        ls_req    = ($urandom_range(0, 2) != 0);
        ls_we     = $urandom_range(0, 1) != 0;
        ls_funct3 = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
        ls_wdata  = $urandom;
        ls_addr   = 32'($urandom_range(0, 252));
        sz = (ls_funct3[1:0] == 2'b00) ? 1 : (ls_funct3[1:0] == 2'b01) ? 2 : 4;
        if ($urandom_range(0, 4) != 0) ls_addr = ls_addr & ~(32'(sz) - 32'd1);
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    fin();
    fin();
  endtask

  task automatic test_memory_final();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = {ref_b[4*i + 3], ref_b[4*i + 2], ref_b[4*i + 1], ref_b[4*i]};
      n_cmp++;
      if (dev_w[i] !== w) begin
        n_bad++; $display("FAIL memory_word%0d: got %h want %h", i, dev_w[i], w);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = '0; ls_wdata = '0;
    model_reset();
    #1;
    preload();
    test_reset();
    test_fetch();
    test_contention();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    test_random();
    test_memory_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
